// File: rtl/yuv_rgb_pkg.sv
// Shared constants and types for the 4:2:2 YCbCr to 4:4:4 RGB converter.
// Holds the BT.601 studio-swing coefficients (Q10), the input offsets, the
// rounding constant/shift, the output clamp limit, the pixel record that
// travels from the pair former into S0, and the pair-former state enum.
package yuv_rgb_pkg;

    localparam int unsigned COEF_Y    = 1192;
    localparam int unsigned COEF_R_CR = 1634;
    localparam int unsigned COEF_G_CR = 832;
    localparam int unsigned COEF_G_CB = 401;
    localparam int unsigned COEF_B_CB = 2066;

    localparam int unsigned Y_OFFSET  = 16;
    localparam int unsigned C_OFFSET  = 128;

    localparam int unsigned RND_CONST = 128;
    localparam int unsigned RND_SHIFT = 8;
    localparam int unsigned CLAMP_MAX = 1023;

    localparam int SUM_W = 22;
    localparam int POS_W = 10;

    typedef enum logic {
        WAIT_EVEN = 1'b0,
        HAVE_EVEN = 1'b1
    } pair_state_e;

    typedef struct packed {
        logic [7:0]       y;
        logic [7:0]       cb;
        logic [7:0]       cr;
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] line;
    } pixel_t;

endpackage

// File: rtl/yuv422_to_rgb_if.sv
// Pixel bus of the converter.
//   Inputs : iYCbCr {Y,chroma}, iDVAL, iTV_X, iTV_Y
//   Outputs: oRed/oGreen/oBlue, oTV_X/oTV_Y, oDVAL, oPAIR_ERR
// master = the side that drives the decoder words and observes RGB,
// slave  = the converter itself.
interface yuv422_to_rgb_if #(
    parameter int OUT_W = 10
);
    logic [15:0]      iYCbCr;
    logic             iDVAL;
    logic [9:0]       iTV_X;
    logic [9:0]       iTV_Y;
    logic [OUT_W-1:0] oRed;
    logic [OUT_W-1:0] oGreen;
    logic [OUT_W-1:0] oBlue;
    logic [9:0]       oTV_X;
    logic [9:0]       oTV_Y;
    logic             oDVAL;
    logic             oPAIR_ERR;

    modport master (
        output iYCbCr, iDVAL, iTV_X, iTV_Y,
        input  oRed, oGreen, oBlue, oTV_X, oTV_Y, oDVAL, oPAIR_ERR
    );

    modport slave (
        input  iYCbCr, iDVAL, iTV_X, iTV_Y,
        output oRed, oGreen, oBlue, oTV_X, oTV_Y, oDVAL, oPAIR_ERR
    );
endinterface

// File: rtl/ycbcr_rgb_matrix.sv
// BT.601 matrix, register stages S1..S3 (products, sums, round/clamp/output).
//   clk, rst              : pixel clock, async active-high reset
//   in_vld/in_y/in_cb/in_cr : offset-corrected pixel from S0 (9-bit signed)
//   in_x/in_line          : position sideband, carried unchanged
//   out_*                 : registered RGB pixel, position and valid strobe;
//                           data/position hold when out_vld is low
module ycbcr_rgb_matrix
    import yuv_rgb_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic signed [8:0]       in_y,
    input  logic signed [8:0]       in_cb,
    input  logic signed [8:0]       in_cr,
    input  logic [POS_W-1:0]        in_x,
    input  logic [POS_W-1:0]        in_line,
    output logic                    out_vld,
    output logic [OUT_W-1:0]        out_r,
    output logic [OUT_W-1:0]        out_g,
    output logic [OUT_W-1:0]        out_b,
    output logic [POS_W-1:0]        out_x,
    output logic [POS_W-1:0]        out_line
);
    // Unsigned Q10 coefficients, zero-extended into the signed sum width.
    localparam logic signed [SUM_W-1:0] K_Y    = SUM_W'(COEF_W'(COEF_Y));
    localparam logic signed [SUM_W-1:0] K_R_CR = SUM_W'(COEF_W'(COEF_R_CR));
    localparam logic signed [SUM_W-1:0] K_G_CR = SUM_W'(COEF_W'(COEF_G_CR));
    localparam logic signed [SUM_W-1:0] K_G_CB = SUM_W'(COEF_W'(COEF_G_CB));
    localparam logic signed [SUM_W-1:0] K_B_CB = SUM_W'(COEF_W'(COEF_B_CB));
    localparam logic signed [SUM_W-1:0] RND    = SUM_W'(RND_CONST);
    localparam logic signed [SUM_W-1:0] MAXV   = SUM_W'(CLAMP_MAX);

    function automatic logic [OUT_W-1:0] round_clamp(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] t;
        t = (s + RND) >>> RND_SHIFT;
        if (t < 0)
            round_clamp = '0;
        else if (t > MAXV)
            round_clamp = OUT_W'(CLAMP_MAX);
        else
            round_clamp = t[OUT_W-1:0];
    endfunction

    logic                    s1_vld_q, s1_vld_d;
    logic signed [SUM_W-1:0] p_y_q, p_y_d, p_rcr_q, p_rcr_d, p_gcr_q, p_gcr_d;
    logic signed [SUM_W-1:0] p_gcb_q, p_gcb_d, p_bcb_q, p_bcb_d;
    logic [POS_W-1:0]        s1_x_q, s1_x_d, s1_line_q, s1_line_d;

    logic                    s2_vld_q, s2_vld_d;
    logic signed [SUM_W-1:0] sum_r_q, sum_r_d, sum_g_q, sum_g_d, sum_b_q, sum_b_d;
    logic [POS_W-1:0]        s2_x_q, s2_x_d, s2_line_q, s2_line_d;

    logic                    o_vld_q, o_vld_d;
    logic [OUT_W-1:0]        o_r_q, o_r_d, o_g_q, o_g_d, o_b_q, o_b_d;
    logic [POS_W-1:0]        o_x_q, o_x_d, o_line_q, o_line_d;

    always_comb begin
        s1_vld_d  = in_vld;
        p_y_d     = SUM_W'(in_y)  * K_Y;
        p_rcr_d   = SUM_W'(in_cr) * K_R_CR;
        p_gcr_d   = SUM_W'(in_cr) * K_G_CR;
        p_gcb_d   = SUM_W'(in_cb) * K_G_CB;
        p_bcb_d   = SUM_W'(in_cb) * K_B_CB;
        s1_x_d    = in_x;
        s1_line_d = in_line;

        s2_vld_d  = s1_vld_q;
        sum_r_d   = p_y_q + p_rcr_q;
        sum_g_d   = p_y_q - p_gcr_q - p_gcb_q;
        sum_b_d   = p_y_q + p_bcb_q;
        s2_x_d    = s1_x_q;
        s2_line_d = s1_line_q;

        o_vld_d  = s2_vld_q;
        o_r_d    = o_r_q;
        o_g_d    = o_g_q;
        o_b_d    = o_b_q;
        o_x_d    = o_x_q;
        o_line_d = o_line_q;
        if (s2_vld_q) begin
            o_r_d    = round_clamp(sum_r_q);
            o_g_d    = round_clamp(sum_g_q);
            o_b_d    = round_clamp(sum_b_q);
            o_x_d    = s2_x_q;
            o_line_d = s2_line_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            p_y_q    <= '0; p_rcr_q <= '0; p_gcr_q <= '0; p_gcb_q <= '0; p_bcb_q <= '0;
            s1_x_q   <= '0; s1_line_q <= '0;
            s2_vld_q <= 1'b0;
            sum_r_q  <= '0; sum_g_q <= '0; sum_b_q <= '0;
            s2_x_q   <= '0; s2_line_q <= '0;
            o_vld_q  <= 1'b0;
            o_r_q    <= '0; o_g_q <= '0; o_b_q <= '0;
            o_x_q    <= '0; o_line_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            p_y_q    <= p_y_d; p_rcr_q <= p_rcr_d; p_gcr_q <= p_gcr_d;
            p_gcb_q  <= p_gcb_d; p_bcb_q <= p_bcb_d;
            s1_x_q   <= s1_x_d; s1_line_q <= s1_line_d;
            s2_vld_q <= s2_vld_d;
            sum_r_q  <= sum_r_d; sum_g_q <= sum_g_d; sum_b_q <= sum_b_d;
            s2_x_q   <= s2_x_d; s2_line_q <= s2_line_d;
            o_vld_q  <= o_vld_d;
            o_r_q    <= o_r_d; o_g_q <= o_g_d; o_b_q <= o_b_d;
            o_x_q    <= o_x_d; o_line_q <= o_line_d;
        end
    end

    assign out_vld  = o_vld_q;
    assign out_r    = o_r_q;
    assign out_g    = o_g_q;
    assign out_b    = o_b_q;
    assign out_x    = o_x_q;
    assign out_line = o_line_q;

endmodule

// File: rtl/yuv422_to_rgb.sv
// 4:2:2 ITU-R 601 stream to 4:4:4 RGB. Pairs even/odd words so both pixels
// share one Cb/Cr, offset-corrects them in S0, and hands them to the matrix.
//   iCLK_27 : pixel clock
//   iRST    : async active-high reset
//   bus     : decoder words in, RGB/position/valid/pair-error out
//
// state     | meaning
// WAIT_EVEN | no pending even word; next even word is stored
// HAVE_EVEN | even word (Y0,Cb,X,Y) stored, waiting for its odd partner
module yuv422_to_rgb
    import yuv_rgb_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int OUT_W  = 10
) (
    input  logic           iCLK_27,
    input  logic           iRST,
    yuv422_to_rgb_if.slave bus
);
    logic [7:0]        in_y, in_c;
    logic              in_odd, pair_match;
    pair_state_e       state_q, state_d;
    pixel_t            even_q, even_d, hold_q, hold_d, s0_src;
    logic              hold_vld_q, hold_vld_d, err_q, err_d;
    logic              store_even, push_pair, set_err, s0_push;
    logic              s0_vld_q, s0_vld_d;
    logic signed [8:0] s0_y_q, s0_y_d, s0_cb_q, s0_cb_d, s0_cr_q, s0_cr_d;
    logic [POS_W-1:0]  s0_x_q, s0_x_d, s0_line_q, s0_line_d;

    assign in_y       = bus.iYCbCr[15:8];
    assign in_c       = bus.iYCbCr[7:0];
    assign in_odd     = bus.iTV_X[0];
    assign pair_match = (bus.iTV_X == even_q.x + POS_W'(1)) && (bus.iTV_Y == even_q.line);

    always_ff @(posedge iCLK_27 or posedge iRST) begin
        if (iRST) state_q <= WAIT_EVEN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.iDVAL) begin
            case (state_q)
                WAIT_EVEN: if (!in_odd) state_d = HAVE_EVEN;
                HAVE_EVEN: if (in_odd)  state_d = WAIT_EVEN;
                default:   state_d = WAIT_EVEN;
            endcase
        end
    end

    always_comb begin
        store_even = 1'b0;
        push_pair  = 1'b0;
        set_err    = 1'b0;
        if (bus.iDVAL) begin
            case (state_q)
                WAIT_EVEN: begin
                    if (!in_odd) store_even = 1'b1;
                    else         set_err    = 1'b1;
                end
                HAVE_EVEN: begin
                    if (!in_odd) begin
                        store_even = 1'b1;
                        set_err    = 1'b1;
                    end else if (pair_match) begin
                        push_pair  = 1'b1;
                    end else begin
                        set_err    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        even_d = even_q;
        if (store_even)
            even_d = '{y: in_y, cb: in_c, cr: 8'd0, x: bus.iTV_X, line: bus.iTV_Y};

        // The odd pixel waits one cycle so the even one can enter S0 first.
        hold_vld_d = push_pair;
        hold_d     = hold_q;
        if (push_pair)
            hold_d = '{y: in_y, cb: even_q.cb, cr: in_c, x: bus.iTV_X, line: bus.iTV_Y};

        err_d = err_q | set_err;

        // A held odd pixel and a new pair can never coincide: the cycle after
        // a pair the former is back in WAIT_EVEN, where nothing pushes.
        s0_push = hold_vld_q | push_pair;
        if (hold_vld_q) begin
            s0_src = hold_q;
        end else begin
            s0_src    = even_q;
            s0_src.cr = in_c;
        end

        s0_vld_d  = s0_push;
        s0_y_d    = $signed({1'b0, s0_src.y}  - 9'(Y_OFFSET));
        s0_cb_d   = $signed({1'b0, s0_src.cb} - 9'(C_OFFSET));
        s0_cr_d   = $signed({1'b0, s0_src.cr} - 9'(C_OFFSET));
        s0_x_d    = s0_src.x;
        s0_line_d = s0_src.line;
    end

    always_ff @(posedge iCLK_27 or posedge iRST) begin
        if (iRST) begin
            even_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            err_q      <= 1'b0;
            s0_vld_q   <= 1'b0;
            s0_y_q     <= '0;
            s0_cb_q    <= '0;
            s0_cr_q    <= '0;
            s0_x_q     <= '0;
            s0_line_q  <= '0;
        end else begin
            even_q     <= even_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            err_q      <= err_d;
            s0_vld_q   <= s0_vld_d;
            s0_y_q     <= s0_y_d;
            s0_cb_q    <= s0_cb_d;
            s0_cr_q    <= s0_cr_d;
            s0_x_q     <= s0_x_d;
            s0_line_q  <= s0_line_d;
        end
    end

    ycbcr_rgb_matrix #(
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W)
    ) u_matrix (
        .clk      (iCLK_27),
        .rst      (iRST),
        .in_vld   (s0_vld_q),
        .in_y     (s0_y_q),
        .in_cb    (s0_cb_q),
        .in_cr    (s0_cr_q),
        .in_x     (s0_x_q),
        .in_line  (s0_line_q),
        .out_vld  (bus.oDVAL),
        .out_r    (bus.oRed),
        .out_g    (bus.oGreen),
        .out_b    (bus.oBlue),
        .out_x    (bus.oTV_X),
        .out_line (bus.oTV_Y)
    );

    assign bus.oPAIR_ERR = err_q;

endmodule

// File: tb/tb_yuv422_to_rgb.sv
// Directed bench for yuv422_to_rgb with hand-computed BT.601 results.
module tb_yuv422_to_rgb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    typedef struct {
        int cyc;
        int x;
        int line;
        int r;
        int g;
        int b;
    } rec_t;

    rec_t got[$];

    yuv422_to_rgb_if bus ();

    yuv422_to_rgb dut (
        .iCLK_27 (clk),
        .iRST    (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.oDVAL)
            got.push_back('{cyc, int'(bus.oTV_X), int'(bus.oTV_Y),
                            int'(bus.oRed), int'(bus.oGreen), int'(bus.oBlue)});
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int y, input int c, input int x, input int line);
        bus.iYCbCr = {y[7:0], c[7:0]};
        bus.iTV_X  = x[9:0];
        bus.iTV_Y  = line[9:0];
        bus.iDVAL  = 1'b1;
        @(posedge clk);
        #1;
        bus.iDVAL  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Even then odd word on consecutive cycles; c = cycle of the odd word.
    task automatic send_pair(input int y0, input int cb, input int y1, input int cr,
                             input int x, input int line, output int c);
        drive(y0, cb, x, line);
        c = cyc;
        drive(y1, cr, x + 1, line);
    endtask

    task automatic check_pix(input string tag, input int ecyc, input int ex, input int eline,
                             input int er, input int eg, input int eb);
        rec_t r;
        chk({tag, "_present"}, int'(got.size() > 0), 1);
        if (got.size() > 0) begin
            r = got.pop_front();
            chk({tag, "_cyc"},  r.cyc,  ecyc);
            chk({tag, "_x"},    r.x,    ex);
            chk({tag, "_line"}, r.line, eline);
            chk({tag, "_r"},    r.r,    er);
            chk({tag, "_g"},    r.g,    eg);
            chk({tag, "_b"},    r.b,    eb);
        end
    endtask

    initial begin
        int c, c2, bad, gray_bad;
        bus.iYCbCr = '0;
        bus.iDVAL  = 1'b0;
        bus.iTV_X  = '0;
        bus.iTV_Y  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dval", bus.oDVAL, 0);
        chk("rst_red",  bus.oRed, 0);
        chk("rst_x",    bus.oTV_X, 0);
        chk("rst_err",  bus.oPAIR_ERR, 0);
        rst = 1'b0;
        idle(2);

        // White, black/white, saturated red, clamp-high pairs
        got.delete();
        send_pair(235, 128, 235, 128, 0, 5, c);
        idle(8);
        check_pix("white_e", c + 4, 0, 5, 1020, 1020, 1020);
        check_pix("white_o", c + 5, 1, 5, 1020, 1020, 1020);

        send_pair(81, 90, 81, 240, 2, 5, c);
        idle(8);
        check_pix("red_e", c + 4, 2, 5, 1018, 0, 0);
        check_pix("red_o", c + 5, 3, 5, 1018, 0, 0);

        send_pair(16, 128, 235, 128, 4, 5, c);
        idle(8);
        check_pix("black_e", c + 4, 4, 5, 0, 0, 0);
        check_pix("black_o", c + 5, 5, 5, 1020, 1020, 1020);

        // G = 1192*239 - 832*127 - 401*127 = 128297 -> 501
        send_pair(255, 255, 255, 255, 6, 5, c);
        idle(8);
        check_pix("sat_e", c + 4, 6, 5, 1023, 501, 1023);
        check_pix("sat_o", c + 5, 7, 5, 1023, 501, 1023);

        chk("hold_dval",  bus.oDVAL, 0);
        chk("hold_blue",  bus.oBlue, 1023);
        chk("hold_green", bus.oGreen, 501);
        chk("hold_x",     bus.oTV_X, 7);
        chk("clean_err",  bus.oPAIR_ERR, 0);
        chk("extra_pix",  got.size(), 0);

        // Full line, valid every other cycle
        got.delete();
        for (int x = 0; x < 720; x++) begin
            drive(235, 128, x, 7);
            idle(1);
        end
        idle(8);
        chk("line_cnt", got.size(), 720);
        bad = 0;
        gray_bad = 0;
        foreach (got[i]) begin
            if (got[i].x != i || got[i].line != 7) bad++;
            if (got[i].r != 1020 || got[i].g != 1020 || got[i].b != 1020) gray_bad++;
        end
        chk("line_order", bad, 0);
        chk("line_data",  gray_bad, 0);
        chk("line_err",   bus.oPAIR_ERR, 0);

        // Missing X=3 word
        got.delete();
        send_pair(235, 128, 235, 128, 0, 9, c);
        drive(235, 128, 2, 9);
        send_pair(81, 90, 81, 240, 4, 9, c2);
        idle(8);
        chk("drop_cnt", got.size(), 4);
        check_pix("drop_0", c + 4,  0, 9, 1020, 1020, 1020);
        check_pix("drop_1", c + 5,  1, 9, 1020, 1020, 1020);
        check_pix("drop_4", c2 + 4, 4, 9, 1018, 0, 0);
        check_pix("drop_5", c2 + 5, 5, 9, 1018, 0, 0);
        chk("drop_err", bus.oPAIR_ERR, 1);
        send_pair(16, 128, 16, 128, 6, 9, c);
        idle(8);
        check_pix("sticky_6", c + 4, 6, 9, 0, 0, 0);
        chk("sticky_err", bus.oPAIR_ERR, 1);

        // Reset clears the flag; an odd word first sets it again
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        chk("rst2_err", bus.oPAIR_ERR, 0);
        got.delete();
        drive(235, 128, 1, 2);
        idle(6);
        chk("odd_first_err", bus.oPAIR_ERR, 1);
        chk("odd_first_out", got.size(), 0);

        send_pair(235, 128, 235, 128, 0, 2, c);
        idle(8);
        check_pix("pre_rst_e", c + 4, 0, 2, 1020, 1020, 1020);
        check_pix("pre_rst_o", c + 5, 1, 2, 1020, 1020, 1020);

        // Reset between the even and odd word of a pair
        drive(235, 128, 10, 3);
        rst = 1'b1;
        #2;
        chk("mid_rst_dval", bus.oDVAL, 0);
        chk("mid_rst_red",  bus.oRed, 0);
        chk("mid_rst_blue", bus.oBlue, 0);
        chk("mid_rst_x",    bus.oTV_X, 0);
        chk("mid_rst_y",    bus.oTV_Y, 0);
        chk("mid_rst_err",  bus.oPAIR_ERR, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        got.delete();
        drive(235, 128, 11, 3);
        idle(6);
        chk("orphan_err", bus.oPAIR_ERR, 1);
        chk("orphan_out", got.size(), 0);
        send_pair(81, 90, 81, 240, 12, 3, c);
        idle(8);
        chk("post_rst_cnt", got.size(), 2);
        check_pix("post_rst_e", c + 4, 12, 3, 1018, 0, 0);
        check_pix("post_rst_o", c + 5, 13, 3, 1018, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
